ag32gbd_ram_read: RTL

AG32GBD_RAM_READ -- requirements
Module: ag32gbd_ram_read

---
 rtl/ag32gbd_ram_read_if.sv | 62 ++++++
 rtl/ag32gbd_ram_read.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ag32gbd_ram_read_if.sv
// ============================================================================
// Module      : ag32gbd_ram_read_if
// Description : Bundle of the control, SRAM-read and buffer-write signals of
//               the ag32gbd_ram_read block.
//               slave  modport : the reader (drives SRAM controls, buffer req)
//               master modport : the environment (start, SRAM data, buffer ack)
//   StartRead            level start request, rising edge starts a block
//   RoundSel             4-bit SRAM page select, latched at start
//   Gbd_Reading_Ram      busy flag for the whole block
//   BlockReadDone        one-cycle completion pulse
//   Ram_Reading_*        SRAM address / nCS / nOE / data
//   WriteBuffer*         buffer write request, offset, data, acknowledge
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ag32gbd_ram_read_if;
    logic        StartRead;
    logic [3:0]  RoundSel;
    logic        Gbd_Reading_Ram;
    logic        BlockReadDone;
    logic [11:0] Ram_Reading_Addr_Low;
    logic        Ram_Reading_nCS;
    logic        Ram_Reading_nOE;
    logic [7:0]  Ram_Reading_Data;
    logic        WriteBufferReq;
    logic [9:0]  WriteBufferOffset;
    logic [7:0]  WriteBufferData;
    logic        WriteBufferAck;

    modport slave (
        input  StartRead,
        input  RoundSel,
        input  Ram_Reading_Data,
        input  WriteBufferAck,
        output Gbd_Reading_Ram,
        output BlockReadDone,
        output Ram_Reading_Addr_Low,
        output Ram_Reading_nCS,
        output Ram_Reading_nOE,
        output WriteBufferReq,
        output WriteBufferOffset,
        output WriteBufferData
    );

    modport master (
        output StartRead,
        output RoundSel,
        output Ram_Reading_Data,
        output WriteBufferAck,
        input  Gbd_Reading_Ram,
        input  BlockReadDone,
        input  Ram_Reading_Addr_Low,
        input  Ram_Reading_nCS,
        input  Ram_Reading_nOE,
        input  WriteBufferReq,
        input  WriteBufferOffset,
        input  WriteBufferData
    );
endinterface

`default_nettype wire

// File: rtl/ag32gbd_ram_read.sv
// ============================================================================
// Module      : ag32gbd_ram_read
// Description : Reads one 256-byte page {RoundSel, 8'hxx} from an async SRAM
//               as 128 byte pairs, bit-interleaves each pair into two bytes
//               and writes them to a buffer through a req/ack handshake.
//   sys_clock   clock, rising edge
//   sys_reset   asynchronous, active-high reset
//   bus         ag32gbd_ram_read_if.slave (start, SRAM read port, buffer port)
//   CE_SETUP    cycles of nCS low before the first read
//   READ_WAIT   cycles of address/nOE valid before each data sample
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ag32gbd_ram_read #(
    parameter int unsigned CE_SETUP  = 10,
    parameter int unsigned READ_WAIT = 6
) (
    input  wire logic          sys_clock,
    input  wire logic          sys_reset,
    ag32gbd_ram_read_if.slave  bus
);

    // One shared counter times both the chip-enable setup and the read wait.
    localparam int unsigned c_CNT_MAX = (CE_SETUP > READ_WAIT) ? CE_SETUP : READ_WAIT;
    localparam int unsigned c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_SETUP_LAST = c_CNT_W'(CE_SETUP - 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST  = c_CNT_W'(READ_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RD0   = 3'd2,
        S_RD1   = 3'd3,
        S_WB0   = 3'd4,
        S_WB1   = 3'd5,
        S_NEXT  = 3'd6
    } state_t;

    state_t             state_q;
    logic [1:0]         start_hist_q;
    logic [3:0]         round_q;
    logic [4:0]         ix_q;
    logic [2:0]         iy_q;
    logic [7:0]         offset_q;
    logic [c_CNT_W-1:0] cnt_q;
    logic [7:0]         b0_q;
    logic [7:0]         b1_q;
    logic               busy_q;
    logic               done_q;
    logic [11:0]        addr_q;
    logic               ncs_q;
    logic               noe_q;
    logic               req_q;
    logic [9:0]         wb_off_q;
    logic [7:0]         wb_data_q;

    logic               w_start_edge;
    logic               w_last_pair;
    logic [7:0]         offset_d;
    logic [9:0]         wb_off_even_d;
    logic [9:0]         wb_off_odd_d;
    logic [7:0]         wb_data_hi_d;
    logic [7:0]         wb_data_lo_d;

    // History resets to "high" so a StartRead already high at reset release
    // must first drop before it can produce an edge.
    assign w_start_edge  = start_hist_q[0] & ~start_hist_q[1];
    assign w_last_pair   = (iy_q == 3'd7) && (ix_q == 5'h1E);
    assign offset_d      = offset_q + 8'd2;
    assign wb_off_even_d = {2'b00, iy_q, ix_q[4:1], 1'b0};
    assign wb_off_odd_d  = {2'b00, iy_q, ix_q[4:1], 1'b1};

    // Interleave the pair: b1 supplies the odd bits, b0 the even bits.
    always_comb begin
        wb_data_hi_d = 8'h00;
        wb_data_lo_d = 8'h00;
        for (int j = 0; j < 4; j++) begin
            wb_data_hi_d[2*j]     = b0_q[4+j];
            wb_data_hi_d[2*j + 1] = b1_q[4+j];
            wb_data_lo_d[2*j]     = b0_q[j];
            wb_data_lo_d[2*j + 1] = b1_q[j];
        end
    end

    always_ff @(posedge sys_clock or posedge sys_reset) begin
        if (sys_reset) begin
            state_q      <= S_IDLE;
            start_hist_q <= 2'b11;
            round_q      <= 4'h0;
            ix_q         <= 5'h00;
            iy_q         <= 3'd0;
            offset_q     <= 8'h00;
            cnt_q        <= '0;
            b0_q         <= 8'h00;
            b1_q         <= 8'h00;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= 12'h000;
            ncs_q        <= 1'b1;
            noe_q        <= 1'b1;
            req_q        <= 1'b0;
            wb_off_q     <= 10'h000;
            wb_data_q    <= 8'h00;
        end else begin
            start_hist_q <= {start_hist_q[0], bus.StartRead};
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (w_start_edge) begin
                        state_q  <= S_SETUP;
                        round_q  <= bus.RoundSel;
                        ix_q     <= 5'h00;
                        iy_q     <= 3'd0;
                        offset_q <= 8'h00;
                        cnt_q    <= '0;
                        ncs_q    <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end

                S_SETUP: begin
                    if (cnt_q == c_SETUP_LAST) begin
                        state_q <= S_RD0;
                        cnt_q   <= '0;
                        addr_q  <= {round_q, offset_q};
                        noe_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                // nOE rises together with the sample so the second byte of the
                // pair always sees a high-nOE gap cycle before its own window.
                S_RD0: begin
                    if (cnt_q == c_WAIT_LAST) begin
                        state_q <= S_RD1;
                        b0_q    <= bus.Ram_Reading_Data;
                        noe_q   <= 1'b1;
                        addr_q  <= {round_q, offset_q[7:1], 1'b1};
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                S_RD1: begin
                    if (noe_q) begin
                        noe_q <= 1'b0;
                        cnt_q <= '0;
                    end else if (cnt_q == c_WAIT_LAST) begin
                        state_q <= S_WB0;
                        b1_q    <= bus.Ram_Reading_Data;
                        noe_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end

                // Each write state spends one cycle with Req low before raising
                // it, which also provides the low gap between two requests.
                S_WB0: begin
                    if (!req_q) begin
                        req_q     <= 1'b1;
                        wb_off_q  <= wb_off_even_d;
                        wb_data_q <= wb_data_hi_d;
                    end else if (bus.WriteBufferAck) begin
                        req_q   <= 1'b0;
                        state_q <= S_WB1;
                    end
                end

                S_WB1: begin
                    if (!req_q) begin
                        req_q     <= 1'b1;
                        wb_off_q  <= wb_off_odd_d;
                        wb_data_q <= wb_data_lo_d;
                    end else if (bus.WriteBufferAck) begin
                        req_q   <= 1'b0;
                        state_q <= S_NEXT;
                    end
                end

                S_NEXT: begin
                    offset_q <= offset_d;
                    if (w_last_pair) begin
                        state_q <= S_IDLE;
                        ncs_q   <= 1'b1;
                        noe_q   <= 1'b1;
                        addr_q  <= 12'h000;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        if (iy_q != 3'd7) begin
                            iy_q <= iy_q + 3'd1;
                        end else begin
                            iy_q <= 3'd0;
                            ix_q <= ix_q + 5'd2;
                        end
                        state_q <= S_RD0;
                        cnt_q   <= '0;
                        addr_q  <= {round_q, offset_d};
                        noe_q   <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    ncs_q   <= 1'b1;
                    noe_q   <= 1'b1;
                    addr_q  <= 12'h000;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Gbd_Reading_Ram      = busy_q;
    assign bus.BlockReadDone        = done_q;
    assign bus.Ram_Reading_Addr_Low = addr_q;
    assign bus.Ram_Reading_nCS      = ncs_q;
    assign bus.Ram_Reading_nOE      = noe_q;
    assign bus.WriteBufferReq       = req_q;
    assign bus.WriteBufferOffset    = wb_off_q;
    assign bus.WriteBufferData      = wb_data_q;

endmodule

`default_nettype wire
